// File: rtl/guess_arbiter_pkg.sv
// Shared types and default sizes for the guessing-game turn arbiter.
package guess_arbiter_pkg;

  typedef enum logic [2:0] {
    S_SEED,
    S_IDLE,
    S_GRANT,
    S_CHECK,
    S_END,
    S_FAIL
  } state_t;

  localparam int DEF_NPLAYERS  = 2;
  localparam int DEF_GUESS_W   = 8;
  localparam int DEF_MAX_TRIES = 7;
  localparam int DEF_TRIES_W   = 4;

endpackage

// File: rtl/guess_arbiter_if.sv
// Player / datapath / status bundle around the turn arbiter.
interface guess_arbiter_if
  import guess_arbiter_pkg::*;
#(
  parameter int NPLAYERS = DEF_NPLAYERS,
  parameter int GUESS_W  = DEF_GUESS_W,
  parameter int TRIES_W  = DEF_TRIES_W
);

  logic [NPLAYERS-1:0]         i_enter;
  logic [NPLAYERS*GUESS_W-1:0] i_guess;
  logic [GUESS_W-1:0]          o_cmp_guess;
  logic                        i_over;
  logic                        i_under;
  logic                        i_equal;
  logic                        o_inc_actual;
  logic                        o_update_leds;
  logic [NPLAYERS-1:0]         o_grant;
  logic [NPLAYERS*TRIES_W-1:0] o_tries;
  logic [NPLAYERS-1:0]         o_winner;
  logic                        o_done;
  logic                        o_fail;

  modport master (
    output i_enter, i_guess,
    output i_over, i_under, i_equal,
    input  o_cmp_guess, o_inc_actual,
    input  o_update_leds, o_grant,
    input  o_tries, o_winner,
    input  o_done, o_fail
  );

  modport slave (
    input  i_enter, i_guess,
    input  i_over, i_under, i_equal,
    output o_cmp_guess, o_inc_actual,
    output o_update_leds, o_grant,
    output o_tries, o_winner,
    output o_done, o_fail
  );

endinterface

// File: rtl/guess_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after i_ptr.
module guess_arbiter_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < N; p++) begin
        if (!w_found && i_req[p] &&
            p == (int'(i_ptr) + k) % N) begin
          o_gnt[p] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/guess_arbiter.sv
// Turn scheduler: seeds actual, captures presses, grants the
// comparator round-robin, tracks tries, declares win or fail.
module guess_arbiter
  import guess_arbiter_pkg::*;
#(
  parameter int NPLAYERS  = DEF_NPLAYERS,
  parameter int GUESS_W   = DEF_GUESS_W,
  parameter int MAX_TRIES = DEF_MAX_TRIES,
  parameter int TRIES_W   = DEF_TRIES_W
) (
  input logic       clk,
  input logic       reset,
  guess_arbiter_if.slave bus
);

  localparam int PW = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;

  state_t               r_state;
  logic [NPLAYERS-1:0]  r_enter_q;
  logic [NPLAYERS-1:0]  r_pending;
  logic [NPLAYERS-1:0]  r_grant;
  logic [NPLAYERS-1:0]  r_winner;
  logic [GUESS_W-1:0]   r_cmp_guess;
  logic                 r_update_leds;
  logic                 r_inc_actual;
  logic                 r_done;
  logic                 r_fail;
  logic [PW-1:0]        r_ptr;
  logic [TRIES_W-1:0]   r_tries [NPLAYERS];

  logic [NPLAYERS-1:0]  w_rise;
  logic [NPLAYERS-1:0]  w_set;
  logic [NPLAYERS-1:0]  w_clr;
  logic [NPLAYERS-1:0]  w_gnt;
  logic [GUESS_W-1:0]   w_gnt_guess;
  logic [PW-1:0]        w_gidx;
  logic [PW-1:0]        w_ptr_nx;
  logic [TRIES_W-1:0]   w_tries_nx [NPLAYERS];
  logic                 w_all_zero;
  logic                 w_live;
  logic                 w_hit;

  assign w_rise = bus.i_enter & ~r_enter_q;
  assign w_live = (r_state != S_END) && (r_state != S_FAIL);
  assign w_clr  = (r_state == S_CHECK) ? r_grant : '0;
  // a clean hit needs equal with neither magnitude flag set
  assign w_hit  = bus.i_equal & ~(bus.i_over | bus.i_under);

  always_comb begin
    for (int p = 0; p < NPLAYERS; p++) begin
      w_set[p] = w_rise[p] && w_live &&
                 (r_tries[p] != '0);
    end
  end

  guess_arbiter_rr_arbiter #(
    .N  (NPLAYERS),
    .PW (PW)
  ) u_rr (
    .i_req (r_pending),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_gnt_guess = '0;
    w_gidx      = '0;
    w_all_zero  = 1'b1;
    for (int p = 0; p < NPLAYERS; p++) begin
      if (w_gnt[p])
        w_gnt_guess |= bus.i_guess[p*GUESS_W +: GUESS_W];
      if (r_grant[p])
        w_gidx = PW'(p);
      w_tries_nx[p] = r_tries[p];
      if (r_grant[p] && r_tries[p] != '0)
        w_tries_nx[p] = r_tries[p] - 1'b1;
      if (w_tries_nx[p] != '0)
        w_all_zero = 1'b0;
    end
  end

  assign w_ptr_nx = (w_gidx == PW'(NPLAYERS - 1)) ?
                    '0 : w_gidx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_SEED;
      r_enter_q     <= '0;
      r_pending     <= '0;
      r_grant       <= '0;
      r_winner      <= '0;
      r_cmp_guess   <= '0;
      r_update_leds <= 1'b0;
      r_inc_actual  <= 1'b1;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_ptr         <= '0;
      for (int p = 0; p < NPLAYERS; p++)
        r_tries[p] <= TRIES_W'(MAX_TRIES);
    end else begin
      r_enter_q     <= bus.i_enter;
      r_pending     <= (r_pending & ~w_clr) | w_set;
      r_update_leds <= 1'b0;
      unique case (r_state)
        S_SEED: begin
          if (|w_rise) begin
            r_inc_actual <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (|r_pending) begin
            r_grant     <= w_gnt;
            r_cmp_guess <= w_gnt_guess;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_update_leds <= 1'b1;
          r_state       <= S_CHECK;
        end
        S_CHECK: begin
          for (int p = 0; p < NPLAYERS; p++)
            r_tries[p] <= w_tries_nx[p];
          r_ptr       <= w_ptr_nx;
          r_grant     <= '0;
          r_cmp_guess <= '0;
          if (w_hit) begin
            r_winner <= r_grant;
            r_done   <= 1'b1;
            r_state  <= S_END;
          end else if (w_all_zero) begin
            r_fail  <= 1'b1;
            r_state <= S_FAIL;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_END, S_FAIL: begin
        end
        default: r_state <= S_SEED;
      endcase
    end
  end

  assign bus.o_cmp_guess   = r_cmp_guess;
  assign bus.o_inc_actual  = r_inc_actual;
  assign bus.o_update_leds = r_update_leds;
  assign bus.o_grant       = r_grant;
  assign bus.o_winner      = r_winner;
  assign bus.o_done        = r_done;
  assign bus.o_fail        = r_fail;

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_tries
    assign bus.o_tries[p*TRIES_W +: TRIES_W] = r_tries[p];
  end

endmodule

// File: tb/tb_guess_arbiter.sv
// Scoreboard bench for guess_arbiter with a small datapath model.
module tb_guess_arbiter;

  localparam int NP = 2;
  localparam int GW = 8;
  localparam int TW = 4;
  localparam int MT = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  guess_arbiter_if #(
    .NPLAYERS (NP), .GUESS_W (GW), .TRIES_W (TW)
  ) bus ();

  guess_arbiter #(
    .NPLAYERS (NP), .GUESS_W (GW),
    .MAX_TRIES (MT), .TRIES_W (TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [GW-1:0] actual;
  logic [GW-1:0] g [NP];

  always @(posedge clk or posedge reset)
    if (reset) actual <= '0;
    else if (bus.o_inc_actual) actual <= actual + 1'b1;

  assign bus.i_over  = bus.o_cmp_guess > actual;
  assign bus.i_under = bus.o_cmp_guess < actual;
  assign bus.i_equal = bus.o_cmp_guess == actual;
  assign bus.i_guess = {g[1], g[0]};

  typedef struct {
    logic [NP-1:0] gnt;
    logic [GW-1:0] guess;
    logic [TW-1:0] tries;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_tries [NP];
  bit   chk_t = 1'b0;
  int   chk_p = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic turn(int p);
    exp_t e;
    exp_tries[p]--;
    e.gnt   = NP'(1) << p;
    e.guess = g[p];
    e.tries = TW'(exp_tries[p]);
    sbq.push_back(e);
  endtask

  task automatic press(logic [NP-1:0] m);
    @(negedge clk);
    bus.i_enter = bus.i_enter | m;
    @(negedge clk);
    bus.i_enter = bus.i_enter & ~m;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sbq.size() != 0 || bus.o_grant != '0) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", 32'(t < 60), 1);
    idle(2);
  endtask

  task automatic rst_model();
    for (int p = 0; p < NP; p++) exp_tries[p] = MT;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk_t = 1'b0;
    end else begin
      if (chk_t) begin
        chk("tries", bus.o_tries[chk_p*TW +: TW], cur.tries);
        chk_t = 1'b0;
      end
      if (bus.o_update_leds) begin
        chk("strobe_expected", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          cur = sbq.pop_front();
          chk("grant", bus.o_grant, cur.gnt);
          chk("cmp_guess", bus.o_cmp_guess, cur.guess);
          for (int p = 0; p < NP; p++)
            if (cur.gnt[p]) chk_p = p;
          chk_t = 1'b1;
        end
      end
    end
  end

  initial begin
    int t;
    bus.i_enter = '0;
    g[0] = 8'd3;
    g[1] = 8'd2;
    rst_model();
    idle(2);
    chk("rst_inc", bus.o_inc_actual, 1);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_strobe", bus.o_update_leds, 0);
    chk("rst_cmp", bus.o_cmp_guess, 0);
    chk("rst_tries", bus.o_tries, {4'd7, 4'd7});
    chk("rst_flags", {bus.o_winner, bus.o_done, bus.o_fail}, 0);
    reset = 1'b0;

    // seed: rise captured on the 5th edge, actual lands on 5
    idle(3);
    chk("seed_inc_hi", bus.o_inc_actual, 1);
    turn(0);
    press(2'b01);
    chk("seed_inc_lo", bus.o_inc_actual, 0);
    chk("seed_actual", actual, 5);
    wait_idle();

    turn(1);
    press(2'b10);
    wait_idle();

    // simultaneous, pointer back at 0
    g[0] = 8'd1;
    g[1] = 8'd9;
    turn(0);
    turn(1);
    press(2'b11);
    wait_idle();

    // p0 re-presses while p1 waits: 01, 10, 01
    g[0] = 8'd4;
    g[1] = 8'd7;
    turn(0);
    turn(1);
    turn(0);
    press(2'b11);
    idle(2);
    press(2'b01);
    wait_idle();
    chk("actual_frozen", actual, 5);

    g[0] = 8'd5;
    turn(0);
    press(2'b01);
    wait_idle();
    chk("win_done", bus.o_done, 1);
    chk("win_winner", bus.o_winner, 2'b01);
    chk("win_fail", bus.o_fail, 0);
    press(2'b11);
    idle(8);
    chk("end_grant", bus.o_grant, 0);
    chk("end_tries0", bus.o_tries[TW-1:0], exp_tries[0]);

    // exhaustion
    @(negedge clk);
    reset = 1'b1;
    rst_model();
    idle(1);
    reset = 1'b0;
    g[0] = 8'd200;
    g[1] = 8'd201;
    for (int i = 0; i < MT; i++) begin
      turn(1);
      press(2'b10);
      wait_idle();
    end
    chk("p1_tries0", bus.o_tries[2*TW-1:TW], 0);
    press(2'b10);
    idle(8);
    chk("p1_dropped", bus.o_grant, 0);
    for (int i = 0; i < MT; i++) begin
      turn(0);
      press(2'b01);
      wait_idle();
    end
    chk("fail_flag", bus.o_fail, 1);
    chk("fail_done", bus.o_done, 0);
    chk("fail_winner", bus.o_winner, 0);
    press(2'b11);
    idle(6);

    // reset while in S_CHECK
    @(negedge clk);
    reset = 1'b1;
    rst_model();
    idle(1);
    reset = 1'b0;
    g[0] = 8'd200;
    turn(0);
    press(2'b01);
    t = 0;
    while (!bus.o_update_leds && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("strobe_seen", bus.o_update_leds, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_grant", bus.o_grant, 0);
    chk("mid_tries", bus.o_tries, {4'd7, 4'd7});
    chk("mid_inc", bus.o_inc_actual, 1);
    chk("mid_strobe", bus.o_update_leds, 0);
    chk("mid_cmp", bus.o_cmp_guess, 0);
    idle(2);
    reset = 1'b0;
    idle(4);
    chk("post_strobe", bus.o_update_leds, 0);
    chk("post_inc", bus.o_inc_actual, 1);
    chk("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
